// File: rtl/div_seq_unit.sv
// Sequential signed divider (DIV semantics): restoring shift-subtract on magnitudes,
// one quotient bit per cycle, followed by a sign-fix step. Quotient feeds LO, remainder HI.
module div_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    count_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   trial;

  // Magnitudes are unsigned, so the most negative value maps to 2**(WIDTH-1).
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // Partial remainder shifted left with the next dividend bit, minus the divisor.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_q  <= StDone;
            end else begin
              quo_q     <= dividend_mag;
              rem_q     <= '0;
              dvs_q     <= divisor_mag;
              neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_rem_q <= dividend[WIDTH-1];
              count_q   <= '0;
              div_zero  <= 1'b0;
              busy      <= 1'b1;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          count_q <= count_q + 1'b1;
          if (count_q == LastCount) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient  <= neg_quo_q ? -quo_q : quo_q;
          remainder <= neg_rem_q ? -rem_q : rem_q;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: a cycle-level arithmetic model checked every cycle,
// plus literal expected results and busy-cycle counts per operation.
module tb_div_seq_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  div_seq_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start yields W+1 busy cycles, then one done cycle carrying
  // the truncating signed quotient and dividend-signed remainder.
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_dz   = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic [W-1:0] p_q    = '0;
  logic [W-1:0] p_r    = '0;
  longint       ma;
  longint       mb;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_q    = p_q;
        m_r    = p_r;
      end
    end else if (start) begin
      if (divisor == '0) begin
        m_dz   = 1'b1;
        m_done = 1'b1;
      end else begin
        ma     = $signed(dividend);
        mb     = $signed(divisor);
        p_q    = W'(ma / mb);
        p_r    = W'(ma % mb);
        m_dz   = 1'b0;
        m_left = W + 1;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", W'(busy), W'(m_left > 0));
      chk("model_done", W'(done), W'(m_done));
      chk("model_div_zero", W'(div_zero), W'(m_dz));
      chk("model_quotient", quotient, m_q);
      chk("model_remainder", remainder, m_r);
    end
  end

  // Called at a negedge; optionally re-pulses start mid-operation (must be ignored).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int ebusy, input int ign_at);
    int nb = 0;
    int t  = 0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'h5A5A_1234;
    divisor  = 32'h0000_0003;
    while (!done && t < 60) begin
      if (busy) nb++;
      if (t == ign_at) begin
        start    = 1'b1;
        dividend = 32'd8;
        divisor  = 32'd2;
      end
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    chk("busy_cycles", W'(nb), W'(ebusy));
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", W'(div_zero), W'(edz));
    @(negedge clk);
    chk("done_single_pulse", W'(done), '0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_div_zero", W'(div_zero), '0);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, -1);
    run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, -1);
    run_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, -1);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, -1);
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);
    run_op(32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 0, -1);
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, -1);
    run_op(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, -1);
    run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 8);

    // Reset in the middle of a division.
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", W'(busy), '0);
    chk("midreset_quotient", quotient, '0);
    chk("midreset_remainder", remainder, '0);
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", W'(done), '0);
    end
    run_op(32'd6, 32'd4, 32'd1, 32'd2, 1'b0, 33, -1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
